// File: rtl/inst_fetch_if.sv
// Instruction-memory request/acknowledge bus between fetch and memory controller.
// The fetch stage is the master; memory answers with a one-cycle ack pulse.
interface inst_fetch_if;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_ack;
   logic [31:0] inst_data;

   modport master (
      output inst_req,
      output inst_addr,
      input  inst_ack,
      input  inst_data
   );

   modport slave (
      input  inst_req,
      input  inst_addr,
      output inst_ack,
      output inst_data
   );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: one outstanding memory request, one-entry output slot,
// redirect handling that lets an in-flight request complete and drops its data.
module inst_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic         clk,
   input  logic         rst,
   inst_fetch_if.master bus,
   input  logic         ifid_stall,
   input  logic         branch_interception,
   input  logic [31:0]  branch_target,
   output logic [31:0]  if_pc,
   output logic [31:0]  if_inst
);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      HOLD,
      FLUSH
   } state_t;

   state_t      state;
   logic [31:0] pc;
   logic        req_q;
   logic [31:0] addr_q;
   logic [31:0] pc_seq;
   logic        ack;
   logic        redir;

   assign pc_seq        = pc + 32'd4;
   assign ack           = bus.inst_ack & req_q;
   assign redir         = branch_interception;
   assign bus.inst_req  = req_q;
   assign bus.inst_addr = addr_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         pc      <= RESET_PC;
         req_q   <= 1'b0;
         addr_q  <= 32'h0;
         if_pc   <= 32'h0;
         if_inst <= 32'h0;
      end else begin
         unique case (state)
            IDLE: begin
               req_q <= 1'b1;
               state <= WAIT;
               if (redir) begin
                  pc     <= branch_target;
                  addr_q <= branch_target;
               end else begin
                  addr_q <= pc;
               end
            end
            WAIT: begin
               if (redir && ack) begin
                  // acked word belongs to the old path: drop it, refetch at once
                  pc     <= branch_target;
                  addr_q <= branch_target;
               end else if (redir) begin
                  pc    <= branch_target;
                  state <= FLUSH;
               end else if (ack) begin
                  if_pc   <= addr_q;
                  if_inst <= bus.inst_data;
                  pc      <= pc_seq;
                  req_q   <= 1'b0;
                  state   <= HOLD;
               end
            end
            HOLD: begin
               if (redir) begin
                  if_pc   <= 32'h0;
                  if_inst <= 32'h0;
                  pc      <= branch_target;
                  req_q   <= 1'b1;
                  addr_q  <= branch_target;
                  state   <= WAIT;
               end else if (!ifid_stall) begin
                  if_pc   <= 32'h0;
                  if_inst <= 32'h0;
                  req_q   <= 1'b1;
                  addr_q  <= pc;
                  state   <= WAIT;
               end
            end
            FLUSH: begin
               // request stays on the bus; only its data is thrown away
               if (redir) begin
                  pc <= branch_target;
               end
               if (ack) begin
                  addr_q <= redir ? branch_target : pc;
                  state  <= WAIT;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: directed scenarios plus randomized
// stall/redirect traffic against a program-order reference model.
module tb_inst_fetch;

   logic        clk;
   logic        rst;
   logic        ifid_stall;
   logic        branch_interception;
   logic [31:0] branch_target;
   logic [31:0] if_pc;
   logic [31:0] if_inst;

   logic        ifid_stall2;
   logic        branch_interception2;
   logic [31:0] branch_target2;
   logic [31:0] if_pc2;
   logic [31:0] if_inst2;

   inst_fetch_if bus ();
   inst_fetch_if bus2 ();

   inst_fetch dut (
      .clk                 (clk),
      .rst                 (rst),
      .bus                 (bus),
      .ifid_stall          (ifid_stall),
      .branch_interception (branch_interception),
      .branch_target       (branch_target),
      .if_pc               (if_pc),
      .if_inst             (if_inst)
   );

   inst_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .clk                 (clk),
      .rst                 (rst),
      .bus                 (bus2),
      .ifid_stall          (ifid_stall2),
      .branch_interception (branch_interception2),
      .branch_target       (branch_target2),
      .if_pc               (if_pc2),
      .if_inst             (if_inst2)
   );

   int          n_cmp;
   int          n_err;
   int          n_pres;
   bit          mon_en;
   bit          rand_lat;
   bit          fixed;
   logic [31:0] fixed_word;
   logic [31:0] exp_q[$];
   logic [31:0] model_next;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[17:2]} | 32'h1;
   endfunction

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic wait_req(input string nm);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(posedge clk); #1;
         seen = bus.inst_req;
      end
      chk(nm, {31'h0, seen}, 32'h1);
   endtask

   task automatic wait_ack(input string nm);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(posedge clk); #4;
         seen = bus.inst_ack;
      end
      chk(nm, {31'h0, seen}, 32'h1);
   endtask

   // memory controller model
   initial begin : memory
      bit          busy;
      int          cnt;
      logic [31:0] req_addr;
      busy = 1'b0;
      cnt = 0;
      req_addr = 32'h0;
      bus.inst_ack = 1'b0;
      bus.inst_data = 32'h0;
      forever begin
         @(posedge clk); #3;
         bus.inst_ack = 1'b0;
         bus.inst_data = 32'h0;
         if (!rst) begin
            busy = 1'b0;
         end else begin
            if (!busy && bus.inst_req) begin
               busy = 1'b1;
               cnt = rand_lat ? int'($urandom_range(0, 3)) : 2;
               req_addr = bus.inst_addr;
            end
            if (busy) begin
               if (cnt == 0) begin
                  busy = 1'b0;
                  bus.inst_ack = 1'b1;
                  bus.inst_data = fixed ? fixed_word : mem_word(bus.inst_addr);
                  chk("addr_stable", bus.inst_addr, req_addr);
               end else begin
                  cnt--;
               end
            end
         end
      end
   end

   // monitor: pops expected presentations and checks hold/clear behaviour
   initial begin : monitor
      bit          prev_pres;
      logic [31:0] prev_pc;
      logic [31:0] prev_inst;
      logic [31:0] e;
      prev_pres = 1'b0;
      prev_pc = 32'h0;
      prev_inst = 32'h0;
      forever begin
         @(posedge clk); #1;
         if (mon_en) begin
            if (branch_interception) begin
               chk("redirect_clear_inst", if_inst, 32'h0);
               chk("redirect_clear_pc", if_pc, 32'h0);
            end else if (prev_pres && ifid_stall) begin
               chk("hold_pc", if_pc, prev_pc);
               chk("hold_inst", if_inst, prev_inst);
            end else if (prev_pres) begin
               chk("consume_bubble", if_inst, 32'h0);
            end else if (if_inst != 32'h0) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_pres", if_inst, 32'h0);
               end else begin
                  e = exp_q.pop_front();
                  chk("pres_pc", if_pc, e);
                  chk("pres_inst", if_inst, mem_word(e));
                  n_pres++;
               end
            end
         end
         prev_pres = (if_inst != 32'h0);
         prev_pc = if_pc;
         prev_inst = if_inst;
      end
   end

   initial begin : main
      bit          pres;
      bit          b;
      bit          s;
      logic [31:0] r;
      n_cmp = 0;
      n_err = 0;
      n_pres = 0;
      mon_en = 1'b0;
      rand_lat = 1'b0;
      fixed = 1'b1;
      fixed_word = 32'h0000_0013;
      model_next = 32'h0;
      rst = 1'b1;
      ifid_stall = 1'b0;
      branch_interception = 1'b0;
      branch_target = 32'h0;
      ifid_stall2 = 1'b0;
      branch_interception2 = 1'b0;
      branch_target2 = 32'h0;
      bus2.inst_ack = 1'b0;
      bus2.inst_data = 32'h0;
      #2 rst = 1'b0;
      #1;
      chk("rst_req", {31'h0, bus.inst_req}, 32'h0);
      chk("rst_addr", bus.inst_addr, 32'h0);
      chk("rst_if_pc", if_pc, 32'h0);
      chk("rst_if_inst", if_inst, 32'h0);

      // first fetch and sequential advance
      @(posedge clk); #2 rst = 1'b1;
      wait_req("first_req_seen");
      chk("first_req_addr", bus.inst_addr, 32'h0);
      wait_ack("first_ack_seen");
      @(posedge clk); #1;
      chk("first_pc", if_pc, 32'h0);
      chk("first_inst", if_inst, 32'h13);
      chk("first_req_drop", {31'h0, bus.inst_req}, 32'h0);
      @(posedge clk); #1;
      chk("second_req", {31'h0, bus.inst_req}, 32'h1);
      chk("second_addr", bus.inst_addr, 32'h4);
      chk("second_bubble", if_inst, 32'h0);

      // stall holds the presented word
      #1;
      ifid_stall = 1'b1;
      fixed_word = 32'h00A0_0093;
      wait_ack("stall_ack_seen");
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("stall_pc", if_pc, 32'h4);
         chk("stall_inst", if_inst, 32'h00A0_0093);
         chk("stall_no_req", {31'h0, bus.inst_req}, 32'h0);
      end
      #1 ifid_stall = 1'b0;
      @(posedge clk); #1;
      chk("stall_consumed", if_inst, 32'h0);
      chk("stall_next_req", {31'h0, bus.inst_req}, 32'h1);
      chk("stall_next_addr", bus.inst_addr, 32'h8);

      // redirect with request outstanding
      #1;
      branch_interception = 1'b1;
      branch_target = 32'h100;
      @(posedge clk); #1;
      chk("flush_req_kept", {31'h0, bus.inst_req}, 32'h1);
      chk("flush_addr_kept", bus.inst_addr, 32'h8);
      #1 branch_interception = 1'b0;
      wait_ack("flush_ack_seen");
      @(posedge clk); #1;
      chk("flush_discard", if_inst, 32'h0);
      chk("flush_target_req", {31'h0, bus.inst_req}, 32'h1);
      chk("flush_target_addr", bus.inst_addr, 32'h100);

      // redirect coinciding with ack
      wait_ack("brack_ack_seen");
      branch_interception = 1'b1;
      branch_target = 32'h40;
      @(posedge clk); #1;
      chk("brack_discard", if_inst, 32'h0);
      chk("brack_req", {31'h0, bus.inst_req}, 32'h1);
      chk("brack_addr", bus.inst_addr, 32'h40);
      #1;
      branch_interception = 1'b0;
      ifid_stall = 1'b1;

      // redirect overrides stall
      wait_ack("brstall_ack_seen");
      @(posedge clk); #1;
      chk("brstall_pres_pc", if_pc, 32'h40);
      #1;
      branch_interception = 1'b1;
      branch_target = 32'h80;
      @(posedge clk); #1;
      chk("brstall_clear_inst", if_inst, 32'h0);
      chk("brstall_clear_pc", if_pc, 32'h0);
      chk("brstall_addr", bus.inst_addr, 32'h80);
      #1;
      branch_interception = 1'b0;
      ifid_stall = 1'b0;

      // randomized traffic against the program-order model
      rst = 1'b0;
      fixed = 1'b0;
      rand_lat = 1'b1;
      exp_q.delete();
      model_next = 32'h0;
      exp_q.push_back(model_next);
      @(posedge clk); #2;
      rst = 1'b1;
      mon_en = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #2;
         pres = (if_inst != 32'h0);
         b = ($urandom_range(0, 11) == 0);
         s = ($urandom_range(0, 2) == 0);
         r = $urandom();
         branch_interception = b;
         branch_target = {r[31:2], 2'b00};
         ifid_stall = s;
         if (b) begin
            exp_q.delete();
            model_next = {r[31:2], 2'b00};
            exp_q.push_back(model_next);
         end else if (pres && !s) begin
            model_next = model_next + 32'd4;
            exp_q.push_back(model_next);
         end
      end
      branch_interception = 1'b0;
      ifid_stall = 1'b0;
      mon_en = 1'b0;
      chk("enough_presentations", {31'h0, n_pres > 100}, 32'h1);

      // asynchronous reset in the middle of a transaction
      wait_req("arst_req_seen");
      #1 rst = 1'b0;
      #1;
      chk("arst_req", {31'h0, bus.inst_req}, 32'h0);
      chk("arst_addr", bus.inst_addr, 32'h0);
      chk("arst_if_pc", if_pc, 32'h0);
      chk("arst_if_inst", if_inst, 32'h0);
      @(posedge clk); #2 rst = 1'b1;
      @(posedge clk); #1;
      chk("arst_post_req", {31'h0, bus.inst_req}, 32'h1);
      chk("arst_post_addr", bus.inst_addr, 32'h0);

      // PC wrap from the top of the address space
      chk("wrap_req1", {31'h0, bus2.inst_req}, 32'h1);
      chk("wrap_addr1", bus2.inst_addr, 32'hFFFF_FFFC);
      #1;
      bus2.inst_ack = 1'b1;
      bus2.inst_data = 32'h13;
      @(posedge clk); #1;
      bus2.inst_ack = 1'b0;
      bus2.inst_data = 32'h0;
      chk("wrap_pres_pc", if_pc2, 32'hFFFF_FFFC);
      chk("wrap_pres_inst", if_inst2, 32'h13);
      @(posedge clk); #1;
      chk("wrap_req2", {31'h0, bus2.inst_req}, 32'h1);
      chk("wrap_addr2", bus2.inst_addr, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
